// File: rtl/ml_ahb_slave_arbiter_pkg.sv
// Shared definitions for the per-slave multilayer AHB arbiter: HTRANS codes, FSM states.
// ML_ARB_LOCK_EN adds the ARB_LOCK state used for hmastlock-atomic sequences.
package ml_ahb_slave_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
`ifdef ML_ARB_LOCK_EN
    ARB_LOCK = 2'b10,
`endif
    ARB_OWN  = 2'b01
  } arb_state_e;

  // SEQ and BUSY continue a burst, so the port must not change hands after them.
  function automatic logic htrans_in_burst(input logic [1:0] htrans);
    return (htrans == HTRANS_SEQ) || (htrans == HTRANS_BUSY);
  endfunction

endpackage

// File: rtl/ml_ahb_rr_pick.sv
// Round-robin one-hot picker: rotate requests by ptr, take the lowest set bit, rotate back.
module ml_ahb_rr_pick
  import ml_ahb_slave_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int MASTER_IDW  = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MASTER_IDW-1:0]  ptr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [MASTER_IDW-1:0]  gnt_idx,
  output logic                   gnt_vld
);

  localparam logic [MASTER_IDW:0] NUM_W = (MASTER_IDW+1)'(NUM_MASTERS);

  logic [2*NUM_MASTERS-1:0] dbl_s;
  logic [NUM_MASTERS-1:0]   rot_s;
  logic [MASTER_IDW-1:0]    rot_idx_s;
  logic [MASTER_IDW:0]      sum_s;

  assign dbl_s   = {req, req} >> ptr;
  assign rot_s   = dbl_s[NUM_MASTERS-1:0];
  assign gnt_vld = |req;

  // Lowest set bit of the rotated vector is the first requester at or after ptr.
  always_comb begin
    rot_idx_s = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      rot_idx_s = rot_s[i] ? MASTER_IDW'(i) : rot_idx_s;
    end
  end

  assign sum_s   = {1'b0, rot_idx_s} + {1'b0, ptr};
  assign gnt_idx = MASTER_IDW'((sum_s >= NUM_W) ? (sum_s - NUM_W) : sum_s);

  // Expand the winning index back to one-hot, gated by any request present.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      gnt[i] = gnt_vld && (gnt_idx == MASTER_IDW'(i));
    end
  end

endmodule

// File: rtl/ml_ahb_slave_arbiter.sv
// Per-slave-port arbiter of the multilayer AHB matrix: round-robin, burst-atomic ownership.
// Optional ML_ARB_LOCK_EN holds ownership across hmastlock sequences.
module ml_ahb_slave_arbiter
  import ml_ahb_slave_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int MASTER_IDW  = 1
) (
  input  logic                     hclk,
  input  logic                     hresetn,
  input  logic [NUM_MASTERS-1:0]   req,
  input  logic [2*NUM_MASTERS-1:0] htrans_flat,
  input  logic [NUM_MASTERS-1:0]   hmastlock,
  input  logic                     hready,
  output logic [NUM_MASTERS-1:0]   grant_addr,
  output logic [NUM_MASTERS-1:0]   grant_data,
  output logic [MASTER_IDW-1:0]    owner_id,
  output logic                     hsel_slave,
  output logic                     busy
);

  arb_state_e             state_q, state_d, state_hold_s;
  logic [NUM_MASTERS-1:0] grant_addr_q, grant_addr_d;
  logic [NUM_MASTERS-1:0] grant_data_q, grant_data_d;
  logic [MASTER_IDW-1:0]  ptr_q, ptr_d;

  logic [NUM_MASTERS-1:0] pick_gnt_s;
  logic [MASTER_IDW-1:0]  pick_idx_s;
  logic [MASTER_IDW-1:0]  ptr_nxt_s;
  logic                   pick_vld_s;
  logic [1:0]             owner_htrans_s;
  logic                   owner_lock_s;
  logic                   at_boundary_s;
  logic                   rearb_s;

  ml_ahb_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .MASTER_IDW  (MASTER_IDW)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (pick_gnt_s),
    .gnt_idx (pick_idx_s),
    .gnt_vld (pick_vld_s)
  );

  // Decode the current address-phase owner: index, its htrans and its lock qualifier.
  always_comb begin
    owner_id       = '0;
    owner_htrans_s = HTRANS_IDLE;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      owner_id       = owner_id | (grant_addr_q[k] ? MASTER_IDW'(k) : '0);
      owner_htrans_s = owner_htrans_s | ({2{grant_addr_q[k]}} & htrans_flat[2*k +: 2]);
    end
  end

`ifdef ML_ARB_LOCK_EN
  assign owner_lock_s = |(grant_addr_q & hmastlock);
`else
  logic unused_lock_s;
  assign unused_lock_s = ^hmastlock;
  assign owner_lock_s  = 1'b0;
`endif

  assign at_boundary_s = hready && !htrans_in_burst(owner_htrans_s);
  assign ptr_nxt_s     = (pick_idx_s == MASTER_IDW'(NUM_MASTERS - 1)) ?
                         '0 : (pick_idx_s + MASTER_IDW'(1));

  // Decide per state whether to re-arbitrate this edge or hold the current owner.
  always_comb begin
    state_hold_s = state_q;
    rearb_s      = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        rearb_s = 1'b1;
      end
      ARB_OWN: begin
        if (at_boundary_s && owner_lock_s) begin
`ifdef ML_ARB_LOCK_EN
          state_hold_s = ARB_LOCK;
`else
          state_hold_s = ARB_OWN;
`endif
        end else begin
          rearb_s = at_boundary_s;
        end
      end
`ifdef ML_ARB_LOCK_EN
      ARB_LOCK: begin
        if (hready && !owner_lock_s) begin
          state_hold_s = ARB_OWN;
          rearb_s      = at_boundary_s;
        end else begin
          state_hold_s = ARB_LOCK;
        end
      end
`endif
      default: begin
        state_hold_s = ARB_IDLE;
        rearb_s      = 1'b1;
      end
    endcase
  end

  // Next owner, state and pointer; grant_data follows grant_addr only on completed beats.
  always_comb begin
    if (rearb_s && pick_vld_s) begin
      state_d      = ARB_OWN;
      grant_addr_d = pick_gnt_s;
      ptr_d        = ptr_nxt_s;
    end else if (rearb_s) begin
      state_d      = ARB_IDLE;
      grant_addr_d = '0;
      ptr_d        = ptr_q;
    end else begin
      state_d      = state_hold_s;
      grant_addr_d = grant_addr_q;
      ptr_d        = ptr_q;
    end
    grant_data_d = hready ? grant_addr_q : grant_data_q;
  end

  // State and grant registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q      <= ARB_IDLE;
      grant_addr_q <= '0;
      grant_data_q <= '0;
      ptr_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_addr_q <= grant_addr_d;
      grant_data_q <= grant_data_d;
      ptr_q        <= ptr_d;
    end
  end

  assign grant_addr = grant_addr_q;
  assign grant_data = grant_data_q;
  assign hsel_slave = |(grant_addr_q & req);
  assign busy       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_ml_ahb_slave_arbiter.sv
// Directed bench for ml_ahb_slave_arbiter: a 2-master instance for ownership/wait/lock/reset
// and a 4-master instance for round-robin order; expected values are hand-derived.
module tb_ml_ahb_slave_arbiter;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
`ifdef ML_ARB_LOCK_EN
  localparam logic LOCK_ON = 1'b1;
`else
  localparam logic LOCK_ON = 1'b0;
`endif

  logic hclk = 1'b0;
  logic hresetn;
  logic hready;

  logic [1:0] req2, lk2, ga2, gd2;
  logic [3:0] ht2;
  logic       id2, hs2, bz2;

  logic [3:0] req4, lk4, ga4, gd4;
  logic [7:0] ht4;
  logic [1:0] id4;
  logic       hs4, bz4;

  int checks   = 0;
  int failures = 0;

  always #5 hclk = ~hclk;

  ml_ahb_slave_arbiter #(.NUM_MASTERS(2), .MASTER_IDW(1)) dut2 (
    .hclk(hclk), .hresetn(hresetn), .req(req2), .htrans_flat(ht2), .hmastlock(lk2),
    .hready(hready), .grant_addr(ga2), .grant_data(gd2), .owner_id(id2),
    .hsel_slave(hs2), .busy(bz2)
  );

  ml_ahb_slave_arbiter #(.NUM_MASTERS(4), .MASTER_IDW(2)) dut4 (
    .hclk(hclk), .hresetn(hresetn), .req(req4), .htrans_flat(ht4), .hmastlock(lk4),
    .hready(hready), .grant_addr(ga4), .grant_data(gd4), .owner_id(id4),
    .hsel_slave(hs4), .busy(bz4)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  initial begin
    hresetn = 1'b0; hready = 1'b1;
    req2 = 2'b00; ht2 = 4'h0; lk2 = 2'b00;
    req4 = 4'h0;  ht4 = 8'h00; lk4 = 4'h0;
    tick(); tick();
    check_eq("rst_ga", 8'(ga2), 8'h00);
    check_eq("rst_gd", 8'(gd2), 8'h00);
    check_eq("rst_id", 8'(id2), 8'h00);
    check_eq("rst_busy", 8'(bz2), 8'h00);
    check_eq("rst_hsel", 8'(hs2), 8'h00);
    hresetn = 1'b1;

    // Single master M0
    req2 = 2'b01; ht2 = {T_IDLE, T_NSEQ};
    tick();
    check_eq("s_ga", 8'(ga2), 8'h01);
    check_eq("s_gd_lag", 8'(gd2), 8'h00);
    check_eq("s_id", 8'(id2), 8'h00);
    check_eq("s_busy", 8'(bz2), 8'h01);
    check_eq("s_hsel", 8'(hs2), 8'h01);
    req2 = 2'b00; ht2 = {T_IDLE, T_IDLE};
    tick();
    check_eq("s_gd", 8'(gd2), 8'h01);
    check_eq("s_release", 8'(ga2), 8'h00);
    check_eq("s_idle_busy", 8'(bz2), 8'h00);
    tick();
    check_eq("s_gd_clr", 8'(gd2), 8'h00);

    // Reset to bring ptr back to 0
    #2 hresetn = 1'b0;
    tick();
    hresetn = 1'b1;

    // Contention: M0 INCR4 holds the port against M1
    req2 = 2'b11; ht2 = {T_NSEQ, T_NSEQ};
    tick();
    check_eq("c_first", 8'(ga2), 8'h01);
    ht2 = {T_NSEQ, T_SEQ};
    for (int b = 0; b < 3; b++) begin
      tick();
      check_eq("c_hold", 8'(ga2), 8'h01);
    end
    req2 = 2'b10; ht2 = {T_NSEQ, T_IDLE};
    tick();
    check_eq("c_switch", 8'(ga2), 8'h02);
    check_eq("c_id", 8'(id2), 8'h01);

    // Wait states during M1 burst; M1 goes IDLE while hready=0
    ht2 = {T_SEQ, T_IDLE};
    tick();
    check_eq("w_gd_pre", 8'(gd2), 8'h02);
    hready = 1'b0; req2 = 2'b11; ht2 = {T_SEQ, T_NSEQ};
    for (int w = 0; w < 3; w++) begin
      if (w == 1) begin
        req2 = 2'b01; ht2 = {T_IDLE, T_NSEQ};
      end
      tick();
      check_eq("w_ga", 8'(ga2), 8'h02);
      check_eq("w_gd", 8'(gd2), 8'h02);
    end
    hready = 1'b1;
    tick();
    check_eq("w_switch", 8'(ga2), 8'h01);
    check_eq("w_gd_post", 8'(gd2), 8'h02);
    ht2 = {T_IDLE, T_SEQ};
    tick();
    check_eq("w_gd_follow", 8'(gd2), 8'h01);

    // Async reset mid-burst of M0
    #2 hresetn = 1'b0;
    #1;
    check_eq("ar_ga", 8'(ga2), 8'h00);
    check_eq("ar_gd", 8'(gd2), 8'h00);
    check_eq("ar_busy", 8'(bz2), 8'h00);
    req2 = 2'b00; ht2 = {T_IDLE, T_IDLE};
    tick();
    hresetn = 1'b1;
    tick();

    // Lock sequence: M0 NONSEQ, IDLE, NONSEQ under hmastlock with M1 requesting
    req2 = 2'b11; ht2 = {T_NSEQ, T_NSEQ}; lk2 = 2'b01;
    tick();
    check_eq("l_grant", 8'(ga2), 8'h01);
    req2 = 2'b10; ht2 = {T_NSEQ, T_IDLE};
    tick();
    check_eq("l_idle", 8'(ga2), LOCK_ON ? 8'h01 : 8'h02);
    req2 = 2'b11; ht2 = {T_NSEQ, T_NSEQ};
    tick();
    check_eq("l_nseq", 8'(ga2), 8'h01);
    req2 = 2'b10; ht2 = {T_NSEQ, T_IDLE}; lk2 = 2'b00;
    tick();
    check_eq("l_release", 8'(ga2), 8'h02);
    req2 = 2'b00; ht2 = {T_IDLE, T_IDLE};
    tick();

    // Round-robin fairness with four always-requesting masters
    req4 = 4'hF; ht4 = {T_NSEQ, T_NSEQ, T_NSEQ, T_NSEQ};
    for (int i = 0; i < 5; i++) begin
      logic [3:0] oh;
      int e;
      e = i % 4;
      oh = 4'b0001 << e;
      tick();
      check_eq("rr_id", 8'(id4), 8'(e));
      check_eq("rr_ga", 8'(ga4), 8'(oh));
    end
    check_eq("rr_gd", 8'(gd4), 8'h08);
    req4 = 4'h0; ht4 = 8'h00;
    tick();
    check_eq("rr_idle_ga", 8'(ga4), 8'h00);
    check_eq("rr_idle_busy", 8'(bz4), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
